fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 100 ++++++++++
 tb/tb_fetch_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch front end. Keeps at most two requests
// in flight, buffers up to four fetched {pc, inst} pairs for ID, and discards
// responses that belong to a path abandoned by a redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h1C00_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  input  logic        id_ready
);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t      state;
  logic [31:0] pc_req;
  logic [1:0]  outstanding;
  logic [1:0]  stale;
  logic        pend_head;
  logic [31:0] pend_pc [2];
  logic [1:0]  buf_head;
  logic [2:0]  buf_count;
  logic [31:0] buf_pc [4];
  logic [31:0] buf_inst [4];

  logic        grant;
  logic        rsp;
  logic        keep;
  logic        pop;
  logic        pend_tail;
  logic [1:0]  buf_tail;
  logic [1:0]  stale_redirect;
  logic [2:0]  in_flight;

  // Handshake decode; the request bound counts in-flight plus buffered words so the buffer can never overflow
  always_comb begin
    in_flight      = {1'b0, outstanding} + buf_count;
    imem_req       = rstn && (state == RUN) && !redirect_valid &&
                     (outstanding != 2'd2) && (in_flight < 3'd4);
    imem_addr      = pc_req & 32'hFFFF_FFFC;
    grant          = imem_req && imem_gnt;
    rsp            = imem_rvalid && (outstanding != 2'd0);
    keep           = rsp && (stale == 2'd0);
    if_valid       = rstn && (buf_count != 3'd0);
    if_pc          = buf_pc[buf_head];
    if_inst        = buf_inst[buf_head];
    pop            = if_valid && id_ready;
    pend_tail      = pend_head ^ outstanding[0];
    buf_tail       = buf_head + buf_count[1:0];
    stale_redirect = outstanding - {1'b0, rsp};
  end

  // Control state: fetch PC, in-flight/stale counters, buffer pointers and RUN/FLUSH mode
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= RUN;
      pc_req      <= RESET_PC;
      outstanding <= 2'd0;
      stale       <= 2'd0;
      pend_head   <= 1'b0;
      buf_head    <= 2'd0;
      buf_count   <= 3'd0;
    end else begin
      outstanding <= outstanding + {1'b0, grant} - {1'b0, rsp};
      if (rsp) pend_head <= ~pend_head;
      if (redirect_valid) begin
        pc_req    <= redirect_pc & 32'hFFFF_FFFC;
        buf_head  <= 2'd0;
        buf_count <= 3'd0;
        stale     <= stale_redirect;
        state     <= (stale_redirect != 2'd0) ? FLUSH : RUN;
      end else begin
        if (grant) pc_req <= pc_req + 32'd4;
        if (rsp && (stale != 2'd0)) stale <= stale - 2'd1;
        if (pop) buf_head <= buf_head + 2'd1;
        buf_count <= buf_count + {2'b00, keep} - {2'b00, pop};
        if ((state == FLUSH) && ((stale == 2'd0) || ((stale == 2'd1) && rsp))) state <= RUN;
      end
    end
  end

  // Payload storage: PCs of requests in flight and the fetched {pc, inst} buffer
  always_ff @(posedge clk) begin
    if (grant) pend_pc[pend_tail] <= pc_req;
    if (rstn && keep && !redirect_valid) begin
      buf_pc[buf_tail]   <= pend_pc[pend_head];
      buf_inst[buf_tail] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven streaming vectors, directed redirect/reset
// sequences and a randomized run checked against a queue-based model.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h1C00_0000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        id_ready;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_inst       (if_inst),
    .id_ready      (id_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: addresses in flight at the memory, the words ID should
  // see in order, how many in-flight responses are stale, and the next fetch PC.
  logic [31:0] mem_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] seen_q[$];
  int          stale_m = 0;
  logic [31:0] fetch_m = RESET_PC;

  typedef struct {
    logic        gnt;
    logic        rv;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[10];

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic model_req();
    return rstn && !redirect_valid && (stale_m == 0) &&
           (mem_q.size() < 2) && (mem_q.size() + exp_q.size() < 4);
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic checkSeen(input string tag, input int idx, input logic [31:0] exp);
    if (idx < seen_q.size()) cmp(tag, seen_q[idx], exp);
    else begin
      total++;
      bad++;
      $display("[TB] FAIL %s: got nothing delivered expected %h", tag, exp);
    end
  endtask

  // Drive one cycle of inputs; memory returns the word for the oldest in-flight address
  task automatic applyStimulus(input logic rn, input logic rd, input logic [31:0] rpc,
                               input logic g, input logic rv, input logic rdy);
    rstn           = rn;
    redirect_valid = rd;
    redirect_pc    = rpc;
    imem_gnt       = g;
    imem_rvalid    = rv;
    id_ready       = rdy;
    imem_rdata     = (mem_q.size() != 0) ? inst_of(mem_q[0]) : 32'hDEAD_BEEF;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag);
    logic er;
    logic ev;
    er = model_req();
    ev = rstn && (exp_q.size() != 0);
    cmp({tag, ".req"}, 32'(imem_req), 32'(er));
    if (er) cmp({tag, ".addr"}, imem_addr, fetch_m);
    cmp({tag, ".valid"}, 32'(if_valid), 32'(ev));
    if (ev) begin
      cmp({tag, ".pc"}, if_pc, exp_q[0]);
      cmp({tag, ".inst"}, if_inst, inst_of(exp_q[0]));
    end
  endtask

  // Cross the clock edge and update the model from the rules of the fetch unit
  task automatic advance();
    logic grant;
    logic pop;
    logic rv_eff;
    logic [31:0] a;
    grant  = model_req() && imem_gnt;
    pop    = rstn && !redirect_valid && (exp_q.size() != 0) && id_ready;
    rv_eff = imem_rvalid && (mem_q.size() != 0);
    if (rstn && !redirect_valid && if_valid && id_ready) seen_q.push_back(if_pc);
    @(posedge clk);
    if (!rstn) begin
      mem_q.delete();
      exp_q.delete();
      stale_m = 0;
      fetch_m = RESET_PC;
    end else if (redirect_valid) begin
      if (rv_eff) void'(mem_q.pop_front());
      exp_q.delete();
      stale_m = mem_q.size();
      fetch_m = {redirect_pc[31:2], 2'b00};
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (rv_eff) begin
        a = mem_q.pop_front();
        if (stale_m > 0) stale_m--;
        else exp_q.push_back(a);
      end
      if (grant) begin
        mem_q.push_back(fetch_m);
        fetch_m = fetch_m + 32'd4;
      end
    end
    #1;
  endtask

  task automatic cyc(input string tag, input logic rn, input logic rd, input logic [31:0] rpc,
                     input logic g, input logic rv, input logic rdy);
    applyStimulus(rn, rd, rpc, g, rv, rdy);
    checkOutput(tag);
    advance();
  endtask

  task automatic stream(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 1'b1, 1'b0, 32'd0, 1'b1, mem_q.size() != 0, 1'b1);
  endtask

  initial begin
    // Streaming table: grant every cycle, response one cycle after grant, ID always ready
    for (int k = 0; k < 10; k++) begin
      tbl[k].gnt     = 1'b1;
      tbl[k].rv      = (k >= 1);
      tbl[k].rdy     = 1'b1;
      tbl[k].e_req   = 1'b1;
      tbl[k].e_addr  = RESET_PC + 32'(4 * k);
      tbl[k].e_valid = (k >= 2);
      tbl[k].e_pc    = RESET_PC + 32'(4 * (k - 2));
    end

    cyc("reset0", 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    cyc("reset1", 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1);

    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 1'b0, 32'd0, tbl[k].gnt, tbl[k].rv, tbl[k].rdy);
      cmp($sformatf("tbl%0d.req", k), 32'(imem_req), 32'(tbl[k].e_req));
      cmp($sformatf("tbl%0d.addr", k), imem_addr, tbl[k].e_addr);
      cmp($sformatf("tbl%0d.valid", k), 32'(if_valid), 32'(tbl[k].e_valid));
      if (tbl[k].e_valid) begin
        cmp($sformatf("tbl%0d.pc", k), if_pc, tbl[k].e_pc);
        cmp($sformatf("tbl%0d.inst", k), if_inst, inst_of(tbl[k].e_pc));
      end
      advance();
    end

    // Back-pressure: ID stalls for 10 cycles, then drains in order
    for (int i = 0; i < 10; i++) cyc("bp_hold", 1'b1, 1'b0, 32'd0, 1'b1, mem_q.size() != 0, 1'b0);
    cmp("bp_hold.req_dropped", 32'(imem_req), 32'd0);
    stream("bp_release", 14);
    for (int i = 0; i < seen_q.size(); i++)
      cmp($sformatf("bp.order%0d", i), seen_q[i], RESET_PC + 32'(4 * i));

    // Redirect with two requests in flight
    for (int i = 0; i < 3; i++) cyc("rd2_setup", 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    seen_q.delete();
    cyc("rd2_redirect", 1'b1, 1'b1, 32'h1C00_0100, 1'b1, 1'b0, 1'b1);
    stream("rd2_after", 10);
    checkSeen("rd2.first_pc", 0, 32'h1C00_0100);

    // Redirect coincident with a response and a pop, then a second redirect while flushing
    cyc("rd3_setup", 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    seen_q.delete();
    cyc("rd3_redirect_a", 1'b1, 1'b1, 32'h1C00_0180, 1'b1, mem_q.size() != 0, 1'b1);
    cyc("rd3_redirect_b", 1'b1, 1'b1, 32'h1C00_0200, 1'b1, 1'b0, 1'b1);
    stream("rd3_after", 10);
    checkSeen("rd3.first_pc", 0, 32'h1C00_0200);
    checkSeen("rd3.second_pc", 1, 32'h1C00_0204);

    // Address wrap and misaligned redirect target
    seen_q.delete();
    cyc("wrap_redirect", 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, mem_q.size() != 0, 1'b1);
    stream("wrap_after", 10);
    checkSeen("wrap.pc0", 0, 32'hFFFF_FFFC);
    checkSeen("wrap.pc1", 1, 32'h0000_0000);
    seen_q.delete();
    cyc("misalign_redirect", 1'b1, 1'b1, 32'h1C00_0102, 1'b1, mem_q.size() != 0, 1'b1);
    stream("misalign_after", 8);
    checkSeen("misalign.pc0", 0, 32'h1C00_0100);

    // Reset with requests in flight and a loaded buffer; late response must be ignored
    cyc("rst_fill_a", 1'b1, 1'b0, 32'd0, 1'b1, mem_q.size() != 0, 1'b0);
    cyc("rst_fill_b", 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    cyc("rst_assert", 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    seen_q.delete();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1);
    cmp("rst.valid_after", 32'(if_valid), 32'd0);
    cmp("rst.req_after", 32'(imem_req), 32'd1);
    cmp("rst.addr_after", imem_addr, RESET_PC);
    checkOutput("rst_first");
    advance();
    stream("rst_after", 8);
    checkSeen("rst.pc0", 0, RESET_PC);
    checkSeen("rst.pc1", 1, RESET_PC + 32'd4);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 5) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      cyc("rand", $urandom_range(0, 299) != 0, $urandom_range(0, 24) == 0, rpc,
          $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
